// File: rtl/ascii_pkg.sv
// Shared constants and types for the ASCII-art path: default frame and cell
// geometry, the values derived from it, and the cell coordinate record.
package ascii_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int CELL_W_DEF   = 8;
    localparam int CELL_H_DEF   = 16;

    localparam int COLS_DEF  = H_ACTIVE_DEF / CELL_W_DEF;
    localparam int ROWS_DEF  = V_ACTIVE_DEF / CELL_H_DEF;
    localparam int SHIFT_DEF = $clog2(CELL_W_DEF * CELL_H_DEF);
    localparam int ACC_W_DEF = 8 + SHIFT_DEF;

    localparam int COL_W = 7;
    localparam int ROW_W = 5;

    typedef struct packed {
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
    } cell_coord_t;

endpackage

// File: rtl/cell_acc_ram.sv
// Per-column partial-sum store: combinational read, registered write.
module cell_acc_ram #(
    parameter int DEPTH  = 80,
    parameter int WIDTH  = 15,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[raddr];

    // NOTE: no reset on the array; the first pixel of every cell overwrites
    // its entry, so stale contents never reach an output.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/cell_luma_averager.sv
// Sums gray pixels over each character cell and emits one rounded average
// per cell, with its column/row, as a single-cycle pulse for the glyph mapper.
module cell_luma_averager
    import ascii_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int CELL_W   = CELL_W_DEF,
    parameter int CELL_H   = CELL_H_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    input  logic             DE,
    input  logic [9:0]       x_pixel,
    input  logic [9:0]       y_pixel,
    input  logic [7:0]       gray,
    output logic             cell_valid,
    output logic [7:0]       cell_gray,
    output logic [COL_W-1:0] cell_col,
    output logic [ROW_W-1:0] cell_row,
    output logic             frame_done
);

    localparam int COLS   = H_ACTIVE / CELL_W;
    localparam int ROWS   = V_ACTIVE / CELL_H;
    localparam int LOG_CW = $clog2(CELL_W);
    localparam int LOG_CH = $clog2(CELL_H);
    localparam int SHIFT  = LOG_CW + LOG_CH;
    localparam int ACC_W  = 8 + SHIFT;
    localparam int SUM_W  = ACC_W + 1;

    logic              sample;
    logic              first_pix;
    logic              last_pix;
    logic              last_cell;
    logic              synced;
    logic [LOG_CW-1:0] sub_x;
    logic [LOG_CH-1:0] sub_y;
    cell_coord_t       here;
    logic [ACC_W-1:0]  acc_rd;
    logic [ACC_W-1:0]  acc_wr;
    logic [SUM_W-1:0]  sum;
    logic [7:0]        avg;

    assign sample = pix_en && DE
                 && (x_pixel < 10'(H_ACTIVE))
                 && (y_pixel < 10'(V_ACTIVE));

    assign sub_x    = x_pixel[LOG_CW-1:0];
    assign sub_y    = y_pixel[LOG_CH-1:0];
    assign here.col = COL_W'(x_pixel >> LOG_CW);
    assign here.row = ROW_W'(y_pixel >> LOG_CH);

    // Cell dimensions are powers of two, so the last pixel is all-ones in both offsets.
    assign first_pix = (sub_x == '0) && (sub_y == '0);
    assign last_pix  = (sub_x == '1) && (sub_y == '1);
    assign last_cell = (here.col == COL_W'(COLS - 1)) && (here.row == ROW_W'(ROWS - 1));

    assign sum    = SUM_W'(acc_rd) + SUM_W'(gray);
    assign acc_wr = first_pix ? ACC_W'(gray) : sum[ACC_W-1:0];
    assign avg    = 8'((sum + SUM_W'(1 << (SHIFT - 1))) >> SHIFT);

    cell_acc_ram #(
        .DEPTH  (COLS),
        .WIDTH  (ACC_W),
        .ADDR_W (COL_W)
    ) u_acc_ram (
        .clk   (clk),
        .we    (sample),
        .waddr (here.col),
        .wdata (acc_wr),
        .raddr (here.col),
        .rdata (acc_rd)
    );

    // NOTE: all state here uses non-blocking assignments so every read in
    // this block sees the pre-edge value (synced gates on its old value).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cell_valid <= 1'b0;
            cell_gray  <= '0;
            cell_col   <= '0;
            cell_row   <= '0;
            frame_done <= 1'b0;
            synced     <= 1'b0;
        end else begin
            cell_valid <= 1'b0;
            frame_done <= 1'b0;
            if (sample) begin
                if (x_pixel == '0 && y_pixel == '0) begin
                    synced <= 1'b1;
                end
                // Cells finishing before the first frame start are partial sums.
                if (last_pix && synced) begin
                    cell_valid <= 1'b1;
                    cell_gray  <= avg;
                    cell_col   <= here.col;
                    cell_row   <= here.row;
                    frame_done <= last_cell;
                end
            end
        end
    end

endmodule

// File: tb/tb_cell_luma_averager.sv
// Self-checking bench for cell_luma_averager on a reduced 64x64 frame, with a
// per-cell averaging model built from the stored image.
module tb_cell_luma_averager;

    localparam int HA = 64;
    localparam int VA = 64;
    localparam int CW = 8;
    localparam int CH = 16;
    localparam int NC = HA / CW;
    localparam int NR = VA / CH;
    localparam int NPIX = CW * CH;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_en = 1'b0;
    logic       de = 1'b0;
    logic [9:0] x = '0;
    logic [9:0] y = '0;
    logic [7:0] g = '0;
    logic       cell_valid;
    logic [7:0] cell_gray;
    logic [6:0] cell_col;
    logic [4:0] cell_row;
    logic       frame_done;

    cell_luma_averager #(
        .H_ACTIVE (HA),
        .V_ACTIVE (VA),
        .CELL_W   (CW),
        .CELL_H   (CH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_en     (pix_en),
        .DE         (de),
        .x_pixel    (x),
        .y_pixel    (y),
        .gray       (g),
        .cell_valid (cell_valid),
        .cell_gray  (cell_gray),
        .cell_col   (cell_col),
        .cell_row   (cell_row),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int col;
        int row;
        int gray;
        bit fd;
    } cell_t;

    typedef struct {
        int n;
        int val;
        int exp;
    } rnd_vec_t;

    cell_t exp_q[$];
    cell_t e;
    int    img[VA][HA];
    int    seen_gray[NR][NC];
    int    done_at[128];
    int    pulses = 0;
    int    fd_pulses = 0;
    int    n_checks = 0;
    int    n_errors = 0;
    int    exp_cells;
    int    exp_fd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every pulse must match the head of the model queue and arrive
    // exactly one clock after its cell's final pixel was sampled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (frame_done && !cell_valid) check("frame_done_without_valid", frame_done, 0);
            if (cell_valid) begin
                pulses++;
                if (frame_done) fd_pulses++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", cell_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("cell_col", cell_col, e.col);
                    check("cell_row", cell_row, e.row);
                    check("cell_gray", cell_gray, e.gray);
                    check("frame_done", frame_done, e.fd);
                end
                check("latency", cyc, done_at[cell_col]);
                if (cell_col < NC && cell_row < NR) seen_gray[cell_row][cell_col] = cell_gray;
            end
        end
    end

    // Reference: a cell is reported if all its lines were fed after sync and
    // before any reset; its value is the rounded mean of its stored pixels.
    task automatic build_expected(input int nlines, input int reset_line);
        int lim;
        int sum;
        cell_t c;
        lim = (reset_line >= 0) ? reset_line : nlines;
        exp_cells = 0;
        exp_fd = 0;
        for (int r = 0; r < NR; r++) begin
            if ((r + 1) * CH <= lim) begin
                for (int cc = 0; cc < NC; cc++) begin
                    sum = 0;
                    for (int py = r * CH; py < (r + 1) * CH; py++)
                        for (int px = cc * CW; px < (cc + 1) * CW; px++)
                            sum += img[py][px];
                    c.col = cc;
                    c.row = r;
                    c.gray = (sum + NPIX / 2) / NPIX;
                    c.fd = (cc == NC - 1) && (r == NR - 1);
                    exp_q.push_back(c);
                    exp_cells++;
                    if (c.fd) exp_fd++;
                end
            end
        end
    endtask

    task automatic pixel(input int period, input bit d, input int xv, input int yv, input int gv);
        repeat (period - 1) begin
            @(negedge clk);
            pix_en = 1'b0;
            de = 1'($urandom);
            x = 10'($urandom_range(0, HA - 1));
            y = 10'($urandom_range(0, VA - 1));
            g = 8'($urandom);
        end
        @(negedge clk);
        pix_en = 1'b1;
        de = d;
        x = 10'(xv);
        y = 10'(yv);
        g = 8'(gv);
        if (d && xv < HA && yv < VA && xv % CW == CW - 1 && yv % CH == CH - 1)
            done_at[xv / CW] = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pix_en = 1'b0;
            de = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        pix_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_cell_valid", cell_valid, 0);
        check("rst_cell_gray", cell_gray, 0);
        check("rst_cell_col", cell_col, 0);
        check("rst_cell_row", cell_row, 0);
        check("rst_frame_done", frame_done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_seen();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                seen_gray[r][c] = -1;
    endtask

    task automatic run_frame(input int nlines, input int period, input bit noise, input int reset_line);
        pulses = 0;
        fd_pulses = 0;
        clear_seen();
        build_expected(nlines, reset_line);
        for (int yy = 0; yy < nlines; yy++) begin
            if (yy == reset_line) do_reset();
            for (int xx = 0; xx < HA; xx++) pixel(period, 1'b1, xx, yy, img[yy][xx]);
            if (noise) begin
                repeat (3) pixel(period, 1'b0, $urandom_range(0, HA - 1), yy, 255);
                repeat (2) pixel(period, 1'b1, $urandom_range(HA, 1023), yy, 255);
            end
        end
        if (noise) repeat (4) pixel(period, 1'b1, $urandom_range(0, HA - 1), $urandom_range(VA, 1023), 255);
        idle(3);
        check("cells_pending", exp_q.size(), 0);
        check("pulse_count", pulses, exp_cells);
        check("frame_done_count", fd_pulses, exp_fd);
    endtask

    task automatic fill_const(input int v);
        for (int yy = 0; yy < VA; yy++)
            for (int xx = 0; xx < HA; xx++)
                img[yy][xx] = v;
    endtask

    task automatic fill_random();
        for (int yy = 0; yy < VA; yy++)
            for (int xx = 0; xx < HA; xx++)
                img[yy][xx] = int'($urandom_range(0, 255));
    endtask

    rnd_vec_t tbl[8];

    initial begin
        // Cell (3,0) holds n pixels of val (raster order), everything else 0.
        tbl[0] = '{n: 64,  val: 1,   exp: 1};
        tbl[1] = '{n: 63,  val: 1,   exp: 0};
        tbl[2] = '{n: 128, val: 255, exp: 255};
        tbl[3] = '{n: 64,  val: 255, exp: 128};
        tbl[4] = '{n: 1,   val: 64,  exp: 1};
        tbl[5] = '{n: 1,   val: 63,  exp: 0};
        tbl[6] = '{n: 128, val: 100, exp: 100};
        tbl[7] = '{n: 96,  val: 3,   exp: 2};

        for (int i = 0; i < 128; i++) done_at[i] = -1;

        repeat (4) @(negedge clk);
        check("init_cell_valid", cell_valid, 0);
        check("init_cell_gray", cell_gray, 0);
        check("init_cell_col", cell_col, 0);
        check("init_cell_row", cell_row, 0);
        check("init_frame_done", frame_done, 0);
        rst_n = 1'b1;
        idle(2);

        // Uniform frame at a slow pixel rate.
        fill_const(100);
        run_frame(VA, 4, 1'b0, -1);
        check("uniform_first_cell", seen_gray[0][0], 100);
        check("uniform_last_cell", seen_gray[NR-1][NC-1], 100);
        check("hold_valid_low", cell_valid, 0);
        check("hold_gray", cell_gray, 100);
        check("hold_col", cell_col, NC - 1);
        check("hold_row", cell_row, NR - 1);

        // Only cell (0,0) bright.
        fill_const(0);
        for (int yy = 0; yy < CH; yy++)
            for (int xx = 0; xx < CW; xx++)
                img[yy][xx] = 255;
        run_frame(VA, 1, 1'b0, -1);
        check("bright_cell00", seen_gray[0][0], 255);
        check("dark_cell10", seen_gray[0][1], 0);
        check("dark_cell01", seen_gray[1][0], 0);

        // Rounding corners, one 16-line band per vector.
        foreach (tbl[i]) begin
            fill_const(0);
            for (int k = 0; k < NPIX; k++)
                img[k / CW][3 * CW + k % CW] = (k < tbl[i].n) ? tbl[i].val : 0;
            run_frame(CH, 1, 1'b0, -1);
            check($sformatf("round_vec%0d", i), seen_gray[0][3], tbl[i].exp);
        end

        // Same random image clean, then with blanking/out-of-range noise.
        fill_random();
        run_frame(VA, 1, 1'b0, -1);
        run_frame(VA, 2, 1'b1, -1);

        // Reset at line 40: nothing after it until the next frame start.
        fill_random();
        run_frame(VA, 1, 1'b0, 40);
        check("post_reset_no_row2", seen_gray[2][0], -1);
        fill_random();
        run_frame(VA, 1, 1'b0, -1);

        // Back-to-back frames with different images.
        fill_const(200);
        run_frame(VA, 1, 1'b0, -1);
        fill_random();
        run_frame(VA, 1, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
